// File: rtl/turn_signal_scheduler_if.sv
// Switch / command bundle between the tail-light front end and its user.
//   left_sw, right_sw, haz_sw : raw switch inputs
//   run_en                    : tick enable, 0 freezes divider and FSM
//   step                      : one-clk pulse per step tick while active
//   cmd                       : latched command {left,haz,right}
//   seq_en                    : high while the scheduler is running
//   cycle_done                : one-clk pulse at the end of each flash cycle
//   step_idx                  : position within the current flash cycle
interface turn_signal_scheduler_if;
   logic       left_sw;
   logic       right_sw;
   logic       haz_sw;
   logic       run_en;
   logic       step;
   logic [2:0] cmd;
   logic       seq_en;
   logic       cycle_done;
   logic [3:0] step_idx;

   modport master (
      output left_sw, right_sw, haz_sw, run_en,
      input  step, cmd, seq_en, cycle_done, step_idx
   );

   modport slave (
      input  left_sw, right_sw, haz_sw, run_en,
      output step, cmd, seq_en, cycle_done, step_idx
   );
endinterface

// File: rtl/turn_signal_scheduler.sv
// Front end for the thunderbird tail-light sequencer: synchronizes and
// debounces the three switches, divides clk down to the step tick, and
// arbitrates the switches into a command that is held for a whole flash
// cycle (hazard may pre-empt a running turn cycle).
// Ports:
//   clk : system clock
//   clr : asynchronous active-high reset
//   bus : turn_signal_scheduler_if.slave (switches, run_en, step/cmd outputs)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no request seen on a tick; cmd=000, no step pulses
// RUN   | flash cycle in progress; step each tick, step_idx counts steps
module turn_signal_scheduler #(
   parameter int DIV         = 500000,
   parameter int DEB         = 16,
   parameter int CYCLE_STEPS = 6
) (
   input  logic                    clk,
   input  logic                    clr,
   turn_signal_scheduler_if.slave  bus
);
   localparam int DW  = $clog2(DEB + 1);
   localparam int DVW = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [3:0] LAST = 4'(CYCLE_STEPS - 1);
   localparam logic [2:0] CMD_HAZ = 3'b010;

   typedef enum logic {IDLE, RUN} state_t;

   // switch vectors are ordered {left, haz, right} to match cmd
   logic [2:0]    raw;
   logic [2:0]    sync1, sync2, filt;
   logic [DW-1:0] deb_cnt [3];
   logic [DVW-1:0] div_cnt;
   logic          tick;
   logic [2:0]    req;

   state_t     state, state_nx;
   logic [2:0] cmd_q, cmd_nx;
   logic [3:0] idx_q, idx_nx;
   logic       step_q, step_nx;
   logic       done_q, done_nx;

   assign raw = {bus.left_sw, bus.haz_sw, bus.right_sw};

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         sync1 <= '0;
         sync2 <= '0;
         filt  <= '0;
         for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         for (int i = 0; i < 3; i++) begin
            if (sync2[i] != filt[i]) begin
               // reaching DEB consecutive disagreements flips the filter
               if (deb_cnt[i] == DW'(DEB - 1)) begin
                  filt[i]    <= ~filt[i];
                  deb_cnt[i] <= '0;
               end else begin
                  deb_cnt[i] <= deb_cnt[i] + 1'b1;
               end
            end else begin
               deb_cnt[i] <= '0;
            end
         end
      end
   end

   assign tick = bus.run_en && (div_cnt == DVW'(DIV - 1));

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         div_cnt <= '0;
      end else if (bus.run_en) begin
         div_cnt <= tick ? '0 : div_cnt + 1'b1;
      end
   end

   // both turn switches together behave as hazard
   always_comb begin
      if (filt[1] || (filt[2] && filt[0])) req = CMD_HAZ;
      else if (filt[2])                    req = 3'b100;
      else if (filt[0])                    req = 3'b001;
      else                                 req = 3'b000;
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state  <= IDLE;
         cmd_q  <= '0;
         idx_q  <= '0;
         step_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state  <= state_nx;
         cmd_q  <= cmd_nx;
         idx_q  <= idx_nx;
         step_q <= step_nx;
         done_q <= done_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cmd_nx   = cmd_q;
      idx_nx   = idx_q;
      step_nx  = 1'b0;
      done_nx  = 1'b0;
      if (tick) begin
         case (state)
            IDLE: begin
               if (req != 3'b000) begin
                  state_nx = RUN;
                  cmd_nx   = req;
                  idx_nx   = '0;
                  step_nx  = 1'b1;
               end
            end
            RUN: begin
               step_nx = 1'b1;
               // the last step completes the cycle even if hazard arrives on
               // it; re-arbitration then picks up the hazard anyway
               if (idx_q == LAST) begin
                  done_nx = 1'b1;
                  idx_nx  = '0;
                  cmd_nx  = req;
                  if (req == 3'b000) state_nx = IDLE;
               end else if (req == CMD_HAZ && cmd_q != CMD_HAZ) begin
                  cmd_nx = CMD_HAZ;
                  idx_nx = '0;
               end else begin
                  idx_nx = idx_q + 1'b1;
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   assign bus.step       = step_q;
   assign bus.cmd        = cmd_q;
   assign bus.seq_en     = (state == RUN);
   assign bus.cycle_done = done_q;
   assign bus.step_idx   = idx_q;
endmodule
